alu_op_sequencer: RTL and testbench

//  Schedules operations onto the shared single-cycle combinational ALU through a valid/ready handshake.

---
 rtl/alu_op_sequencer.sv | 151 +++++++++++++++
 tb/tb_alu_op_sequencer.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/alu_op_sequencer.sv
// Issues requests onto a shared single-cycle ALU. Plain ops take one pass; MUL is a
// shift-add loop that reuses the ALU adder, one partial product per cycle.
module alu_op_sequencer #(
  parameter int unsigned WIDTH      = 32,
  parameter bit          EARLY_EXIT = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [3:0]       req_op,
  input  logic [WIDTH-1:0] req_a,
  input  logic [WIDTH-1:0] req_b,
  input  logic             flush,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_result,
  output logic             rsp_zero,
  output logic             busy,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [3:0]       alu_control,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_zero
);

  localparam int unsigned     IterW    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [IterW-1:0] LastIter = IterW'(WIDTH - 1);
  localparam logic [3:0]      OpAdd    = 4'b0010;

  typedef enum logic [1:0] {StIdle, StExec, StDone} state_e;

  state_e           state_q, state_d;
  logic [3:0]       op_q, op_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             zero_q, zero_d;
  logic [IterW-1:0] iter_q, iter_d;

  logic             is_mul;
  logic             mul_last;
  logic [WIDTH-1:0] acc_next;

  assign is_mul   = op_q[3];
  // Partial product is only added when the current multiplier bit is set.
  assign acc_next = mplier_q[0] ? alu_result : acc_q;
  assign mul_last = (iter_q == LastIter) || (EARLY_EXIT && ((mplier_q >> 1) == '0));

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    mcand_d     = mcand_q;
    mplier_d    = mplier_q;
    acc_d       = acc_q;
    iter_d      = iter_q;
    result_d    = result_q;
    zero_d      = zero_q;
    alu_a       = '0;
    alu_b       = '0;
    alu_control = 4'b0000;

    unique case (state_q)
      StIdle: begin
        if (req_valid) begin
          op_d     = req_op;
          mcand_d  = req_a;
          mplier_d = req_b;
          acc_d    = '0;
          iter_d   = '0;
          state_d  = StExec;
        end
      end

      StExec: begin
        if (is_mul) begin
          alu_a       = acc_q;
          alu_b       = mcand_q;
          alu_control = OpAdd;
        end else begin
          alu_a       = mcand_q;
          alu_b       = mplier_q;
          alu_control = op_q;
        end

        if (flush) begin
          result_d = '0;
          zero_d   = 1'b0;
          state_d  = StIdle;
        end else if (!is_mul) begin
          result_d = alu_result;
          zero_d   = alu_zero;
          state_d  = StDone;
        end else begin
          acc_d    = acc_next;
          mcand_d  = mcand_q << 1;
          mplier_d = mplier_q >> 1;
          iter_d   = iter_q + IterW'(1);
          if (mul_last) begin
            // Zero flag from the final accumulator; alu_zero may reflect an unused sum.
            result_d = acc_next;
            zero_d   = (acc_next == '0);
            state_d  = StDone;
          end
        end
      end

      StDone: begin
        if (flush) begin
          result_d = '0;
          zero_d   = 1'b0;
          state_d  = StIdle;
        end else if (rsp_ready) begin
          state_d = StIdle;
        end
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      op_q     <= 4'b0000;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      iter_q   <= '0;
      result_q <= '0;
      zero_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      iter_q   <= iter_d;
      result_q <= result_d;
      zero_q   <= zero_d;
    end
  end

  assign req_ready  = (state_q == StIdle);
  assign busy       = (state_q != StIdle);
  assign rsp_valid  = (state_q == StDone);
  assign rsp_result = result_q;
  assign rsp_zero   = zero_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench for alu_op_sequencer with a behavioural ALU and a response scoreboard.
module tb_alu_op_sequencer;

  localparam int unsigned W = 32;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         req_valid = 1'b0;
  logic         req_ready;
  logic [3:0]   req_op = 4'b0000;
  logic [W-1:0] req_a = '0;
  logic [W-1:0] req_b = '0;
  logic         flush = 1'b0;
  logic         rsp_valid;
  logic         rsp_ready = 1'b1;
  logic [W-1:0] rsp_result;
  logic         rsp_zero;
  logic         busy;
  logic [W-1:0] alu_a;
  logic [W-1:0] alu_b;
  logic [3:0]   alu_control;
  logic [W-1:0] alu_result;
  logic         alu_zero;

  typedef struct {
    logic [W-1:0] result;
    logic         zero;
    int           lat;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass = 0;

  always #5 clk = ~clk;

  alu_op_sequencer #(.WIDTH(W), .EARLY_EXIT(1'b1)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_a(req_a), .req_b(req_b), .flush(flush),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_result(rsp_result), .rsp_zero(rsp_zero), .busy(busy),
    .alu_a(alu_a), .alu_b(alu_b), .alu_control(alu_control),
    .alu_result(alu_result), .alu_zero(alu_zero)
  );

  function automatic logic [W-1:0] ref_op(input logic [3:0] op, input logic [W-1:0] a,
                                          input logic [W-1:0] b);
    if (op[3]) return a * b;
    case (op)
      4'b0000: return a & b;
      4'b0001: return a | b;
      4'b0010: return a + b;
      4'b0011: return a ^ b;
      4'b0110: return a - b;
      4'b0111: return ($signed(a) < $signed(b)) ? 1 : 0;
      default: return '0;
    endcase
  endfunction

  // Shared ALU seen by the sequencer.
  always_comb begin
    alu_result = ref_op({1'b0, alu_control[2:0]} | {alu_control[3], 3'b000} & 4'b0111,
                        alu_a, alu_b);
    if (alu_control[3]) alu_result = '0;
    alu_zero = (alu_result == '0);
  end

  function automatic int mul_iters(input logic [W-1:0] b);
    for (int i = W - 1; i >= 0; i--) if (b[i]) return i + 1;
    return 1;
  endfunction

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic push_exp(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    e.result = ref_op(op, a, b);
    e.zero   = (e.result == '0);
    e.lat    = op[3] ? 1 + mul_iters(b) : 2;
    sb.push_back(e);
  endtask

  // Called at the negedge after the accept edge; returns cycles from accept to rsp_valid.
  task automatic wait_rsp(input string tag, input logic [3:0] op, output int lat);
    lat = 1;
    while (!rsp_valid && lat < 100) begin
      chk({tag, " exec alu_control"}, {28'd0, alu_control}, {28'd0, op[3] ? 4'b0010 : op});
      @(negedge clk);
      lat++;
    end
    chk({tag, " rsp_valid"}, {31'd0, rsp_valid}, 1);
  endtask

  task automatic check_rsp(input string tag, input int lat);
    exp_t e;
    if (sb.size() == 0) begin
      chk({tag, " scoreboard empty"}, 1, 0);
      return;
    end
    e = sb.pop_front();
    chk({tag, " latency"}, lat, e.lat);
    chk({tag, " result"}, rsp_result, e.result);
    chk({tag, " zero"}, {31'd0, rsp_zero}, {31'd0, e.zero});
  endtask

  task automatic run_op(input string tag, input logic [3:0] op, input logic [W-1:0] a,
                        input logic [W-1:0] b);
    int lat;
    push_exp(op, a, b);
    chk({tag, " req_ready"}, {31'd0, req_ready}, 1);
    req_valid = 1'b1; req_op = op; req_a = a; req_b = b;
    @(negedge clk);
    req_valid = 1'b0;
    wait_rsp(tag, op, lat);
    check_rsp(tag, lat);
    @(negedge clk);
    chk({tag, " idle busy"}, {31'd0, busy}, 0);
    chk({tag, " idle alu_control"}, {28'd0, alu_control}, 0);
  endtask

  initial begin
    int lat;

    // Reset state
    #1;
    chk("rst rsp_valid", {31'd0, rsp_valid}, 0);
    chk("rst rsp_result", rsp_result, 0);
    chk("rst rsp_zero", {31'd0, rsp_zero}, 0);
    chk("rst busy", {31'd0, busy}, 0);
    chk("rst alu_a", alu_a, 0);
    chk("rst alu_b", alu_b, 0);
    chk("rst alu_control", {28'd0, alu_control}, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post-rst req_ready", {31'd0, req_ready}, 1);

    run_op("add 7+5", 4'b0010, 32'd7, 32'd5);
    run_op("sub 5-5", 4'b0110, 32'd5, 32'd5);
    run_op("slt 3<9", 4'b0111, 32'd3, 32'd9);
    run_op("and", 4'b0000, 32'hF0F0_1234, 32'h0FF0_FF00);
    run_op("or", 4'b0001, 32'hF000_0001, 32'h000F_0010);
    run_op("slt neg", 4'b0111, 32'hFFFF_FFFE, 32'd1);
    run_op("undef 0100", 4'b0100, 32'd3, 32'd4);
    run_op("mul 6*7", 4'b1000, 32'd6, 32'd7);
    run_op("mul msb", 4'b1101, 32'd3, 32'h8000_0000);
    run_op("mul wrap", 4'b1000, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run_op("mul b0", 4'b1000, 32'd123, 32'd0);

    // Backpressure with a second request held pending
    rsp_ready = 1'b0;
    push_exp(4'b0010, 32'd10, 32'd20);
    req_valid = 1'b1; req_op = 4'b0010; req_a = 32'd10; req_b = 32'd20;
    @(negedge clk);
    req_op = 4'b0011; req_a = 32'h0000_00F0; req_b = 32'h0000_00FF;
    wait_rsp("bp add", 4'b0010, lat);
    check_rsp("bp add", lat);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp hold result", rsp_result, 32'd30);
      chk("bp hold valid", {31'd0, rsp_valid}, 1);
      chk("bp req_ready", {31'd0, req_ready}, 0);
    end
    rsp_ready = 1'b1;
    push_exp(4'b0011, 32'h0000_00F0, 32'h0000_00FF);
    @(negedge clk);
    chk("bp no same-cycle accept", {31'd0, busy}, 0);
    chk("bp rsp dropped", {31'd0, rsp_valid}, 0);
    @(negedge clk);
    req_valid = 1'b0;
    wait_rsp("bp xor", 4'b0011, lat);
    check_rsp("bp xor", lat);
    @(negedge clk);

    // Flush at MUL iteration 10
    req_valid = 1'b1; req_op = 4'b1000; req_a = 32'd3; req_b = 32'hFFFF_FFFF;
    @(negedge clk);
    req_valid = 1'b0;
    repeat (10) @(negedge clk);
    chk("flush in exec", {31'd0, busy}, 1);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("flush busy", {31'd0, busy}, 0);
    chk("flush req_ready", {31'd0, req_ready}, 1);
    chk("flush alu_control", {28'd0, alu_control}, 0);
    chk("flush alu_a", alu_a, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("flush no rsp", {31'd0, rsp_valid}, 0);
    end

    // Async reset mid-EXEC
    req_valid = 1'b1; req_op = 4'b1000; req_a = 32'd5; req_b = 32'h0000_FFFF;
    @(negedge clk);
    req_valid = 1'b0;
    repeat (4) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst busy", {31'd0, busy}, 0);
    chk("arst rsp_valid", {31'd0, rsp_valid}, 0);
    chk("arst rsp_result", rsp_result, 0);
    chk("arst alu_control", {28'd0, alu_control}, 0);
    chk("arst alu_b", alu_b, 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("arst no rsp", {31'd0, rsp_valid}, 0);
    end
    run_op("add after rst", 4'b0010, 32'd100, 32'd23);

    chk("scoreboard drained", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
